// File: rtl/baccarat_pkg.sv
// Shared types and thresholds for the baccarat round sequencer.
package baccarat_pkg;

  typedef enum logic [3:0] {
    IDLE, P1, D1, P2, D2, EVAL, P3, D3DEC, D3, RESULT
  } state_t;

  localparam logic [3:0] NATURAL_MIN  = 4'd8;
  localparam logic [3:0] PLAYER_STAND = 4'd6;

  // Banker third-card tableau, used only after the player has drawn a third card.
  function automatic logic dealer_draws(input logic [3:0] dscore, input logic [3:0] pcard3);
    logic draw;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pcard3 != 4'd8);
      4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

endpackage

// File: rtl/round_tally.sv
// Saturating win/loss/tie counters, updated once per finished round.
module round_tally #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             result_vld,
  input  logic             player_ge,
  input  logic             dealer_ge,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      player_wins <= '0;
      dealer_wins <= '0;
      ties        <= '0;
    end else if (result_vld) begin
      case ({player_ge, dealer_ge})
        2'b10:   player_wins <= sat_inc(player_wins);
        2'b01:   dealer_wins <= sat_inc(dealer_wins);
        2'b11:   ties        <= sat_inc(ties);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Baccarat round control FSM: deals cards, applies drawing rules, latches result lights.
// Define ROUND_TALLY_EN to add saturating player/dealer/tie round counters.
module round_sequencer
  import baccarat_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             card_req,
  input  logic             card_ack,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             busy,
  output logic             done,
  output logic             player_win_light,
  output logic             dealer_win_light
`ifdef ROUND_TALLY_EN
  ,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("round_sequencer: CNT_W must be at least 1");
  end

  state_t state, state_nxt;
  logic   take;
  logic   player_ge;
  logic   dealer_ge;

  // Reset blocks a same-cycle ack from strobing a datapath load.
  assign take      = card_ack && !rst;
  assign player_ge = (pscore >= dscore);
  assign dealer_ge = (dscore >= pscore);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start)    state_nxt = P1;
      P1:     if (card_ack) state_nxt = D1;
      D1:     if (card_ack) state_nxt = P2;
      P2:     if (card_ack) state_nxt = D2;
      D2:     if (card_ack) state_nxt = EVAL;
      EVAL: begin
        if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) state_nxt = RESULT;
        else if (pscore < PLAYER_STAND)                     state_nxt = P3;
        else if (dscore < PLAYER_STAND)                     state_nxt = D3;
        else                                                state_nxt = RESULT;
      end
      P3:     if (card_ack) state_nxt = D3DEC;
      D3DEC:  state_nxt = dealer_draws(dscore, pcard3) ? D3 : RESULT;
      D3:     if (card_ack) state_nxt = RESULT;
      RESULT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    card_req    = 1'b0;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    case (state)
      P1: begin card_req = 1'b1; load_pcard1 = take; end
      D1: begin card_req = 1'b1; load_dcard1 = take; end
      P2: begin card_req = 1'b1; load_pcard2 = take; end
      D2: begin card_req = 1'b1; load_dcard2 = take; end
      P3: begin card_req = 1'b1; load_pcard3 = take; end
      D3: begin card_req = 1'b1; load_dcard3 = take; end
      default: ;
    endcase
  end

  // Lights persist through IDLE and clear only when a new round is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      done             <= 1'b0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end else begin
      done <= (state == RESULT);
      if (state == IDLE && start) begin
        player_win_light <= 1'b0;
        dealer_win_light <= 1'b0;
      end else if (state == RESULT) begin
        player_win_light <= player_ge;
        dealer_win_light <= dealer_ge;
      end
    end
  end

`ifdef ROUND_TALLY_EN
  round_tally #(.CNT_W(CNT_W)) u_tally (
    .clk         (clk),
    .rst         (rst),
    .result_vld  (state == RESULT),
    .player_ge   (player_ge),
    .dealer_ge   (dealer_ge),
    .player_wins (player_wins),
    .dealer_wins (dealer_wins),
    .ties        (ties)
  );
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer; tally checks are active when ROUND_TALLY_EN is defined.
module tb_round_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, card_ack;
  logic [3:0] pscore, dscore, pcard3;
  logic       card_req, busy, done, player_win_light, dealer_win_light;
  logic       load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3;
  logic [5:0] strobes;
`ifdef ROUND_TALLY_EN
  logic [7:0] player_wins, dealer_wins, ties;
  logic       card_req2, busy2, done2, pl2, dl2;
  logic [5:0] strobes2;
  logic [1:0] player_wins2, dealer_wins2, ties2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_cyc, multi;
  int seen_cyc[6];
  logic lights_c1;

  typedef struct {
    logic [3:0] ps, ds, pc3;
    int         done_c, p3_c, d3_c;
    logic       pl, dl;
  } vec_t;

  always #5 clk = ~clk;

  assign strobes = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};

  round_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .card_req(card_req), .card_ack(card_ack),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .busy(busy), .done(done), .player_win_light(player_win_light), .dealer_win_light(dealer_win_light)
`ifdef ROUND_TALLY_EN
    , .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties)
`endif
  );

`ifdef ROUND_TALLY_EN
  round_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .card_req(card_req2), .card_ack(card_ack),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(strobes2[0]), .load_pcard2(strobes2[2]), .load_pcard3(strobes2[4]),
    .load_dcard1(strobes2[1]), .load_dcard2(strobes2[3]), .load_dcard3(strobes2[5]),
    .busy(busy2), .done(done2), .player_win_light(pl2), .dealer_win_light(dl2),
    .player_wins(player_wins2), .dealer_wins(dealer_wins2), .ties(ties2)
  );
`endif

  // Runs one round with card_ack held high; called ~1-2ns after a rising edge with the DUT idle.
  task automatic run_round(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3);
    pscore = ps; dscore = ds; pcard3 = pc3; card_ack = 1'b1; start = 1'b1;
    done_cyc = -1; multi = 0; lights_c1 = 1'bx;
    for (int i = 0; i < 6; i++) seen_cyc[i] = -1;
    for (int n = 1; n <= 20 && done_cyc < 0; n++) begin
      @(posedge clk); #1; start = 1'b0; #1;
      if ($countones(strobes) > 1) multi++;
      for (int i = 0; i < 6; i++) if (strobes[i] && seen_cyc[i] < 0) seen_cyc[i] = n;
      if (n == 1) lights_c1 = player_win_light | dealer_win_light;
      if (done) done_cyc = n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; card_ack = 1'b1; pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({busy, card_req, done, player_win_light, dealer_win_light} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {busy, card_req, done, player_win_light, dealer_win_light}); end
    n_checks++; if (strobes !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 000000", strobes); end
`ifdef ROUND_TALLY_EN
    n_checks++; if ({player_wins, dealer_wins, ties} !== 24'b0) begin
      n_fail++; $display("FAIL reset_tallies: got %h expected 000000", {player_wins, dealer_wins, ties}); end
`endif
    rst = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_overrides_start: busy got %b expected 0", busy); end
    @(posedge clk); #2;
    n_checks++; if ({card_req, strobes} !== 7'b0) begin
      n_fail++; $display("FAIL idle_ack_ignored: got %b expected 0000000", {card_req, strobes}); end
  endtask

  task automatic test_naturals();
    vec_t v[2];
    v[0] = '{4'd8, 4'd3, 4'd0, 7, -1, -1, 1'b1, 1'b0};
    v[1] = '{4'd2, 4'd9, 4'd0, 7, -1, -1, 1'b0, 1'b1};
    foreach (v[k]) begin
      run_round(v[k].ps, v[k].ds, v[k].pc3);
      n_checks++; if (done_cyc !== v[k].done_c) begin n_fail++;
        $display("FAIL natural%0d_done_cycle: got %0d expected %0d", k, done_cyc, v[k].done_c); end
      n_checks++; if ({seen_cyc[0], seen_cyc[1], seen_cyc[2], seen_cyc[3]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin n_fail++;
        $display("FAIL natural%0d_deal_cycles: got %0d %0d %0d %0d expected 1 2 3 4", k, seen_cyc[0], seen_cyc[1], seen_cyc[2], seen_cyc[3]); end
      n_checks++; if ({seen_cyc[4], seen_cyc[5]} !== {v[k].p3_c, v[k].d3_c}) begin n_fail++;
        $display("FAIL natural%0d_third_cards: got p3=%0d d3=%0d expected none", k, seen_cyc[4], seen_cyc[5]); end
      n_checks++; if ({player_win_light, dealer_win_light, multi[0]} !== {v[k].pl, v[k].dl, 1'b0}) begin n_fail++;
        $display("FAIL natural%0d_lights: got pl=%b dl=%b multi=%0d expected pl=%b dl=%b multi=0", k, player_win_light, dealer_win_light, multi, v[k].pl, v[k].dl); end
    end
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if ({player_win_light, dealer_win_light, done} !== 3'b010) begin n_fail++;
      $display("FAIL lights_hold: got pl/dl/done=%b expected 010", {player_win_light, dealer_win_light, done}); end
  endtask

  task automatic test_third_cards();
    vec_t v[2];
    v[0] = '{4'd4, 4'd5, 4'd6, 10, 6, 8, 1'b0, 1'b1};
    v[1] = '{4'd4, 4'd5, 4'd8, 9, 6, -1, 1'b0, 1'b1};
    foreach (v[k]) begin
      run_round(v[k].ps, v[k].ds, v[k].pc3);
      n_checks++; if (lights_c1 !== 1'b0) begin n_fail++;
        $display("FAIL third%0d_lights_cleared_on_start: got %b expected 0", k, lights_c1); end
      n_checks++; if (done_cyc !== v[k].done_c) begin n_fail++;
        $display("FAIL third%0d_done_cycle: got %0d expected %0d", k, done_cyc, v[k].done_c); end
      n_checks++; if ({seen_cyc[4], seen_cyc[5]} !== {v[k].p3_c, v[k].d3_c}) begin n_fail++;
        $display("FAIL third%0d_strobe_cycles: got p3=%0d d3=%0d expected p3=%0d d3=%0d", k, seen_cyc[4], seen_cyc[5], v[k].p3_c, v[k].d3_c); end
      n_checks++; if ({player_win_light, dealer_win_light, multi[0]} !== {v[k].pl, v[k].dl, 1'b0}) begin n_fail++;
        $display("FAIL third%0d_lights: got pl=%b dl=%b multi=%0d expected pl=%b dl=%b multi=0", k, player_win_light, dealer_win_light, multi, v[k].pl, v[k].dl); end
    end
  endtask

  task automatic test_player_stands();
    vec_t v[2];
    v[0] = '{4'd7, 4'd5, 4'd0, 8, -1, 6, 1'b1, 1'b0};
    v[1] = '{4'd6, 4'd6, 4'd0, 7, -1, -1, 1'b1, 1'b1};
    foreach (v[k]) begin
      run_round(v[k].ps, v[k].ds, v[k].pc3);
      n_checks++; if (done_cyc !== v[k].done_c) begin n_fail++;
        $display("FAIL stand%0d_done_cycle: got %0d expected %0d", k, done_cyc, v[k].done_c); end
      n_checks++; if ({seen_cyc[4], seen_cyc[5]} !== {v[k].p3_c, v[k].d3_c}) begin n_fail++;
        $display("FAIL stand%0d_strobe_cycles: got p3=%0d d3=%0d expected p3=%0d d3=%0d", k, seen_cyc[4], seen_cyc[5], v[k].p3_c, v[k].d3_c); end
      n_checks++; if ({player_win_light, dealer_win_light} !== {v[k].pl, v[k].dl}) begin n_fail++;
        $display("FAIL stand%0d_lights: got pl=%b dl=%b expected pl=%b dl=%b", k, player_win_light, dealer_win_light, v[k].pl, v[k].dl); end
    end
`ifdef ROUND_TALLY_EN
    n_checks++; if ({player_wins, dealer_wins, ties} !== {8'd2, 8'd3, 8'd1}) begin n_fail++;
      $display("FAIL tally_counts: got p=%0d d=%0d t=%0d expected p=2 d=3 t=1", player_wins, dealer_wins, ties); end
`endif
  endtask

  task automatic test_stalled_deck();
    int stall_bad = 0;
    pscore = 4'd8; dscore = 4'd3; pcard3 = 4'd0; card_ack = 1'b1; start = 1'b1;
    done_cyc = -1;
    @(posedge clk); #1; start = 1'b0; #1;
    n_checks++; if (load_pcard1 !== 1'b1) begin n_fail++;
      $display("FAIL stall_pcard1: got %b expected 1", load_pcard1); end
    for (int n = 2; n <= 6; n++) begin
      @(posedge clk); #1; card_ack = 1'b0; start = 1'b1; #1;
      if ({card_req, busy, strobes} !== 8'b11_000000) stall_bad++;
    end
    n_checks++; if (stall_bad !== 0) begin n_fail++;
      $display("FAIL stall_hold: got %0d bad cycles expected 0", stall_bad); end
    @(posedge clk); #1; card_ack = 1'b1; start = 1'b0; #1;
    n_checks++; if (strobes !== 6'b000010) begin n_fail++;
      $display("FAIL stall_resume_dcard1: got %b expected 000010", strobes); end
    for (int n = 8; n <= 25 && done_cyc < 0; n++) begin
      @(posedge clk); #2;
      if (done) done_cyc = n;
    end
    n_checks++; if (done_cyc !== 12) begin n_fail++;
      $display("FAIL stall_done_cycle: got %0d expected 12", done_cyc); end
    n_checks++; if ({player_win_light, dealer_win_light} !== 2'b10) begin n_fail++;
      $display("FAIL stall_lights: got %b expected 10", {player_win_light, dealer_win_light}); end
  endtask

  task automatic test_reset_mid_round();
    pscore = 4'd4; dscore = 4'd5; pcard3 = 4'd6; card_ack = 1'b1; start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1; start = 1'b0; #1;
    end
    n_checks++; if (load_pcard3 !== 1'b1) begin n_fail++;
      $display("FAIL midreset_in_p3: load_pcard3 got %b expected 1", load_pcard3); end
    rst = 1'b1; #1;
    n_checks++; if (strobes !== 6'b0) begin n_fail++;
      $display("FAIL midreset_ack_override: got %b expected 000000", strobes); end
    @(posedge clk); #1; rst = 1'b0; #1;
    n_checks++; if ({busy, card_req, done, player_win_light, dealer_win_light, strobes} !== 11'b0) begin n_fail++;
      $display("FAIL midreset_outputs: got %b expected all zero", {busy, card_req, done, player_win_light, dealer_win_light, strobes}); end
`ifdef ROUND_TALLY_EN
    n_checks++; if ({player_wins, dealer_wins, ties} !== 24'b0) begin n_fail++;
      $display("FAIL midreset_tallies: got %h expected 000000", {player_wins, dealer_wins, ties}); end
`endif
    @(posedge clk); #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL midreset_stays_idle: busy got %b expected 0", busy); end
  endtask

`ifdef ROUND_TALLY_EN
  task automatic test_saturation();
    for (int r = 0; r < 5; r++) run_round(4'd9, 4'd2, 4'd0);
    n_checks++; if (player_wins !== 8'd5) begin n_fail++;
      $display("FAIL sat_wide_player: got %0d expected 5", player_wins); end
    n_checks++; if ({player_wins2, dealer_wins2, ties2} !== {2'd3, 2'd0, 2'd0}) begin n_fail++;
      $display("FAIL sat_narrow: got p=%0d d=%0d t=%0d expected p=3 d=0 t=0", player_wins2, dealer_wins2, ties2); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_naturals();
    test_third_cards();
    test_player_stands();
    test_stalled_deck();
    test_reset_mid_round();
`ifdef ROUND_TALLY_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of each round tally counter.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  begin-round request; sampled only in IDLE.
REQ-005 The block SHALL have port card_req  output  1  requests a card from the deck source.
REQ-006 The block SHALL have port card_ack  input  1  deck card valid this cycle; meaningful only while card_req=1.
REQ-007 The block SHALL have ports pscore, dscore, pcard3  input  4 each  datapath hand totals (0-9) and player third card value.
REQ-008 The block SHALL have ports load_pcard1..3, load_dcard1..3  output  1 each  single-cycle datapath card-register load strobes.
REQ-009 The block SHALL have ports busy  output  1, and done  output  1 (one-cycle pulse at round end).
REQ-010 The block SHALL have ports player_win_light, dealer_win_light  output  1 each  registered result lights.
REQ-011 With ROUND_TALLY_EN defined, the block SHALL have ports player_wins, dealer_wins, ties  output  CNT_W each.

Function
REQ-012 The FSM SHALL have states IDLE, P1, D1, P2, D2, EVAL, P3, D3DEC, D3, RESULT.
REQ-013 IDLE: busy=0, card_req=0; start=1 -> P1, clear both lights.
REQ-014 P1/D1/P2/D2/P3/D3: card_req=1, busy=1; stay until card_ack=1.
REQ-015 In a deal state with card_ack=1, the matching load strobe SHALL be asserted combinationally that same cycle, and the FSM SHALL advance at the next edge.
REQ-016 Deal-state successors: P1->D1->P2->D2->EVAL; P3->D3DEC; D3->RESULT.
REQ-017 EVAL (one cycle): pscore>=8 or dscore>=8 -> RESULT; else pscore<=5 -> P3; else dscore<=5 -> D3; else -> RESULT.
REQ-018 D3DEC (one cycle), dealer draws (-> D3) when: dscore 0-2 always; 3 if pcard3!=8; 4 if pcard3 in 2..7; 5 if pcard3 in 4..7; 6 if pcard3 in 6..7; 7 never (-> RESULT).
REQ-019 RESULT (one cycle): player_win_light <= pscore>=dscore, dealer_win_light <= dscore>=pscore (tie lights both); done=1; -> IDLE.
REQ-020 Scores SHALL be read only in EVAL, D3DEC, RESULT, so each sees cards loaded on the prior edge.
REQ-021 Lights SHALL hold their values until the next accepted start or reset.
REQ-022 start while busy=1 SHALL be ignored; card_ack while card_req=0 SHALL be ignored with no load strobe.
REQ-023 No more than one load strobe SHALL be high in any cycle; no strobe outside deal states.
REQ-024 Minimum round latency, with card_ack held high: start accepted -> done = 7 cycles (naturals) to 10 cycles (both third cards).

Reset
REQ-025 rst=1 at any clock edge, including mid-round, SHALL force IDLE with all outputs 0 and tallies 0 on the next cycle.
REQ-026 rst SHALL override start and card_ack in the same cycle.

Configuration
REQ-027 With ROUND_TALLY_EN defined, each RESULT SHALL increment exactly one of player_wins (player only), dealer_wins (dealer only), or ties (both), each saturating at 2^CNT_W-1.
REQ-028 Without ROUND_TALLY_EN, the tally ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package baccarat_pkg SHALL hold the state enum, the natural threshold (8), and the player-stand threshold (6).
REQ-030 Tally counters SHALL be the sub-module round_tally, instantiated only under ROUND_TALLY_EN.

Verification
REQ-031 Naturals: start, card_ack=1, pscore=8, dscore=3 at EVAL -> no P3/D3 strobes, done at cycle 7, player light only.
REQ-032 Third cards: pscore=4, then dscore=5 with pcard3=6 at D3DEC -> load_pcard3 then load_dcard3; with pcard3=8 -> no load_dcard3.
REQ-033 Player stands: pscore=7, dscore=5 -> load_dcard3 only; pscore=6, dscore=6 -> no draws, both lights set, ties increments.
REQ-034 Stalled deck: card_ack low 5 cycles in D1 -> card_req held, no strobes, round resumes on ack; start pulses meanwhile ignored.
REQ-035 Reset mid-round: rst in P3 -> IDLE next cycle, all outputs and tallies 0; CNT_W=2 with 5 player wins -> player_wins=3.
